// File: rtl/lfsr_rng.sv
// lfsr_rng: Fibonacci XNOR LFSR random source with seed loading, a step
// enable and a request/valid draw port. A draw returns a value in
// 0..RANGE-1 by rejection sampling on the low OUT_W register bits; after
// MAX_TRIES rejections the draw is forced to complete (candidate - RANGE).
//
// Parameters:
//   WIDTH     LFSR width, one of 8/16/24/32
//   SEED      reset and lockup-replacement value (truncated to WIDTH)
//   OUT_W     width of the drawn value
//   RANGE     exclusive upper bound of the drawn value (1..2**OUT_W)
//   MAX_TRIES rejections after which a draw is forced to complete
//
// Ports:
//   i_Clk        clock, rising edge
//   i_Rst        synchronous active-high reset
//   i_Enable     step the LFSR once per cycle while idle
//   i_Seed_DV    one-cycle seed-load strobe
//   i_Seed_Data  seed value (all-ones loads SEED instead)
//   i_Req        draw request, sampled only while idle
//   o_Busy       high while a draw is in progress
//   o_Valid      one-cycle pulse, o_Rand/o_Forced valid
//   o_Rand       drawn value, held until the next draw completes
//   o_Forced     the completed draw hit MAX_TRIES
//   o_LFSR_Data  current register state
//   o_Reject_Cnt saturating count of rejected candidates
//                (only with RNG_REJECT_COUNT_EN defined)
//
// Optional feature macro: RNG_REJECT_COUNT_EN
module lfsr_rng #(
  parameter int unsigned WIDTH     = 16,
  parameter logic [31:0] SEED      = 32'h0000_9999,
  parameter int unsigned OUT_W     = 4,
  parameter int unsigned RANGE     = 10,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Enable,
  input  logic             i_Seed_DV,
  input  logic [WIDTH-1:0] i_Seed_Data,
  input  logic             i_Req,
  output logic             o_Busy,
  output logic             o_Valid,
  output logic [OUT_W-1:0] o_Rand,
  output logic             o_Forced,
  output logic [WIDTH-1:0] o_LFSR_Data
`ifdef RNG_REJECT_COUNT_EN
  ,
  output logic [15:0]      o_Reject_Cnt
`endif
);

  // Tap positions as a bit mask over r[WIDTH:1] (bit t-1 for tap t).
  function automatic logic [31:0] tap_mask32(input int unsigned w);
    case (w)
      8:       return 32'h0000_00B8;  // 8,6,5,4
      16:      return 32'h0000_D008;  // 16,15,13,4
      24:      return 32'h00E1_0000;  // 24,23,22,17
      32:      return 32'h8020_0003;  // 32,22,2,1
      default: return 32'h0000_0000;
    endcase
  endfunction

  localparam int unsigned    TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(tap_mask32(WIDTH));
  localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [OUT_W:0]   RANGE_X  = (OUT_W + 1)'(RANGE);
  localparam logic [OUT_W-1:0] RANGE_T  = OUT_W'(RANGE);

  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
    $error("lfsr_rng: WIDTH must be 8, 16, 24 or 32");
  end
  if (SEED_W == '1) begin : g_bad_seed
    $error("lfsr_rng: SEED must not be all-ones");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
    $error("lfsr_rng: OUT_W must be in 1..WIDTH");
  end
  if (RANGE < 1 || RANGE > (2 ** OUT_W)) begin : g_bad_range
    $error("lfsr_rng: RANGE must be in 1..2**OUT_W");
  end
  if (MAX_TRIES < 1) begin : g_bad_tries
    $error("lfsr_rng: MAX_TRIES must be at least 1");
  end

  typedef enum logic {
    S_IDLE,
    S_DRAW
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] rand_q, rand_d;
  logic             forced_q, forced_d;

  logic             fb;
  logic [WIDTH-1:0] step_val;
  logic [OUT_W-1:0] cand;
  logic             accept;

  assign fb     = ~(^(lfsr_q & TAP_MASK));
  assign cand   = lfsr_q[OUT_W-1:0];
  assign accept = ({1'b0, cand} < RANGE_X);

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    valid_d  = 1'b0;
    rand_d   = rand_q;
    forced_d = forced_q;
    lfsr_d   = lfsr_q;

    // All-ones is the XNOR lockup state; never step into it.
    step_val = {lfsr_q[WIDTH-2:0], fb};
    if (step_val == '1) begin
      step_val = SEED_W;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_Req) begin
          state_d = S_DRAW;
          tries_d = '0;
        end
      end
      S_DRAW: begin
        if (accept) begin
          rand_d   = cand;
          valid_d  = 1'b1;
          forced_d = 1'b0;
          state_d  = S_IDLE;
        end else if (tries_q == LAST_TRY) begin
          rand_d   = cand - RANGE_T;
          valid_d  = 1'b1;
          forced_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A seed load replaces the step; a draw in progress keeps its tries and
    // sees the loaded value as its next candidate.
    if (i_Seed_DV) begin
      lfsr_d = (i_Seed_Data == '1) ? SEED_W : i_Seed_Data;
    end else if (state_q == S_DRAW || i_Enable) begin
      lfsr_d = step_val;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_W;
      tries_q  <= '0;
      valid_q  <= 1'b0;
      rand_q   <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      tries_q  <= tries_d;
      valid_q  <= valid_d;
      rand_q   <= rand_d;
      forced_q <= forced_d;
    end
  end

  assign o_Busy      = (state_q == S_DRAW);
  assign o_Valid     = valid_q;
  assign o_Rand      = rand_q;
  assign o_Forced    = forced_q;
  assign o_LFSR_Data = lfsr_q;

`ifdef RNG_REJECT_COUNT_EN
  logic        reject;
  logic [15:0] rej_cnt_q, rej_cnt_d;

  // Forced completions are rejected candidates too.
  assign reject = (state_q == S_DRAW) && !accept;

  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (reject && rej_cnt_q != '1) begin
      rej_cnt_d = rej_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rej_cnt_q <= '0;
    end else begin
      rej_cnt_q <= rej_cnt_d;
    end
  end

  assign o_Reject_Cnt = rej_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_rng.sv
module tb_lfsr_rng;

  logic        clk;
  logic        rst, en, sdv, req;
  logic [15:0] sd;

  logic        busy0, valid0, forced0;
  logic [3:0]  rand0;
  logic [15:0] lfsr0;
  logic        busy1, valid1, forced1;
  logic [3:0]  rand1;
  logic [15:0] lfsr1;
  logic        busy2, valid2, forced2;
  logic [3:0]  rand2;
  logic [15:0] lfsr2;
`ifdef RNG_REJECT_COUNT_EN
  logic [15:0] rej0, rej1, rej2;
`endif

  int errors = 0;
  int checks = 0;

  // Default build
  lfsr_rng u_dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(sdv),
    .i_Seed_Data(sd), .i_Req(req), .o_Busy(busy0), .o_Valid(valid0),
    .o_Rand(rand0), .o_Forced(forced0), .o_LFSR_Data(lfsr0)
`ifdef RNG_REJECT_COUNT_EN
    , .o_Reject_Cnt(rej0)
`endif
  );

  // Every rejection forces completion
  lfsr_rng #(.MAX_TRIES(1)) u_dut1 (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(sdv),
    .i_Seed_Data(sd), .i_Req(req), .o_Busy(busy1), .o_Valid(valid1),
    .o_Rand(rand1), .o_Forced(forced1), .o_LFSR_Data(lfsr1)
`ifdef RNG_REJECT_COUNT_EN
    , .o_Reject_Cnt(rej1)
`endif
  );

  // Full range: every candidate accepted
  lfsr_rng #(.RANGE(16)) u_dut16 (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(sdv),
    .i_Seed_Data(sd), .i_Req(req), .o_Busy(busy2), .o_Valid(valid2),
    .o_Rand(rand2), .o_Forced(forced2), .o_LFSR_Data(lfsr2)
`ifdef RNG_REJECT_COUNT_EN
    , .o_Reject_Cnt(rej2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] lfsr;
    logic        busy;
    int unsigned tries;
    logic        valid;
    logic [3:0]  rnd;
    logic        forced;
    int unsigned rej;
  } model_t;

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    int unsigned taps[4] = '{16, 15, 13, 4};
    int unsigned ones = 0;
    logic [15:0] n;
    foreach (taps[i]) ones += int'(s[taps[i] - 1]);
    n = {s[14:0], ((ones % 2) == 0) ? 1'b1 : 1'b0};
    if (n == 16'hFFFF) n = 16'h9999;
    return n;
  endfunction

  function automatic model_t ref_next(input model_t m, input logic r, input logic e,
                                      input logic ld, input logic [15:0] d, input logic q,
                                      input int unsigned rng, input int unsigned maxt);
    model_t n = m;
    int unsigned c;
    if (r) begin
      n.lfsr = 16'h9999; n.busy = 0; n.tries = 0; n.valid = 0;
      n.rnd = 0; n.forced = 0; n.rej = 0;
      return n;
    end
    n.valid = 0;
    if (m.busy) begin
      c = int'(m.lfsr) % 16;
      if (c < rng) begin
        n.valid = 1; n.rnd = 4'(c); n.forced = 0; n.busy = 0;
      end else begin
        if (m.rej < 65535) n.rej = m.rej + 1;
        if (m.tries + 1 == maxt) begin
          n.valid = 1; n.rnd = 4'(c - rng); n.forced = 1; n.busy = 0;
        end else begin
          n.tries = m.tries + 1;
        end
      end
    end else if (q) begin
      n.busy = 1; n.tries = 0;
    end
    if (ld) n.lfsr = (d == 16'hFFFF) ? 16'h9999 : d;
    else if (m.busy || e) n.lfsr = ref_step(m.lfsr);
    return n;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic ld,
                       input logic [15:0] d, input logic q);
    rst = r; en = e; sdv = ld; sd = d; req = q;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rst, en, sdv;
    logic [15:0] sd;
    logic        req;
    logic [15:0] e_lfsr;
    logic        e_busy, e_valid;
    logic [3:0]  e_rand;
    logic        e_forced;
    logic [15:0] e_rej;
  } vec_t;

  vec_t vecs[22];

  model_t m0, m1, m2;
  string  nm;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

    //           rst en sdv sd        req  lfsr     busy valid rand forced rej
    vecs[0]  = '{1, 0, 0, 16'h0000, 0, 16'h9999, 0, 0, 4'd0, 0, 16'd0};
    vecs[1]  = '{0, 1, 0, 16'h0000, 0, 16'h3332, 0, 0, 4'd0, 0, 16'd0};
    vecs[2]  = '{1, 0, 0, 16'h0000, 0, 16'h9999, 0, 0, 4'd0, 0, 16'd0};
    vecs[3]  = '{0, 0, 0, 16'h0000, 1, 16'h9999, 1, 0, 4'd0, 0, 16'd0};
    vecs[4]  = '{0, 0, 0, 16'h0000, 0, 16'h3332, 0, 1, 4'd9, 0, 16'd0};
    vecs[5]  = '{0, 0, 1, 16'h000F, 0, 16'h000F, 0, 0, 4'd9, 0, 16'd0};
    vecs[6]  = '{0, 0, 0, 16'h0000, 1, 16'h000F, 1, 0, 4'd9, 0, 16'd0};
    vecs[7]  = '{0, 0, 0, 16'h0000, 0, 16'h001E, 1, 0, 4'd9, 0, 16'd1};
    vecs[8]  = '{0, 0, 0, 16'h0000, 0, 16'h003C, 1, 0, 4'd9, 0, 16'd2};
    vecs[9]  = '{0, 0, 0, 16'h0000, 0, 16'h0078, 1, 0, 4'd9, 0, 16'd3};
    vecs[10] = '{0, 0, 0, 16'h0000, 0, 16'h00F0, 0, 1, 4'd8, 0, 16'd3};
    vecs[11] = '{0, 0, 1, 16'hFFFF, 0, 16'h9999, 0, 0, 4'd8, 0, 16'd3};
    vecs[12] = '{0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 4'd8, 0, 16'd3};
    vecs[13] = '{0, 0, 0, 16'h0000, 1, 16'h0000, 1, 0, 4'd8, 0, 16'd3};
    vecs[14] = '{0, 0, 0, 16'h0000, 0, 16'h0001, 0, 1, 4'd0, 0, 16'd3};
    vecs[15] = '{0, 0, 0, 16'h0000, 1, 16'h0001, 1, 0, 4'd0, 0, 16'd3};
    vecs[16] = '{1, 0, 0, 16'h0000, 0, 16'h9999, 0, 0, 4'd0, 0, 16'd0};
    vecs[17] = '{0, 0, 0, 16'h0000, 0, 16'h9999, 0, 0, 4'd0, 0, 16'd0};
    vecs[18] = '{0, 0, 0, 16'h0000, 1, 16'h9999, 1, 0, 4'd0, 0, 16'd0};
    vecs[19] = '{0, 1, 0, 16'h0000, 1, 16'h3332, 0, 1, 4'd9, 0, 16'd0};
    vecs[20] = '{0, 0, 0, 16'h0000, 1, 16'h3332, 1, 0, 4'd9, 0, 16'd0};
    vecs[21] = '{0, 1, 0, 16'h0000, 0, 16'h6664, 0, 1, 4'd2, 0, 16'd0};

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].sdv, vecs[i].sd, vecs[i].req);
      tick();
      nm = $sformatf("vec%0d", i);
      check({nm, ".lfsr"},   64'(lfsr0),   64'(vecs[i].e_lfsr));
      check({nm, ".busy"},   64'(busy0),   64'(vecs[i].e_busy));
      check({nm, ".valid"},  64'(valid0),  64'(vecs[i].e_valid));
      check({nm, ".rand"},   64'(rand0),   64'(vecs[i].e_rand));
      check({nm, ".forced"}, 64'(forced0), 64'(vecs[i].e_forced));
`ifdef RNG_REJECT_COUNT_EN
      check({nm, ".rej"},    64'(rej0),    64'(vecs[i].e_rej));
`endif
    end

    // ---------------- forced completion / full range ----------------
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 16'h000F, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1); tick();
    check("mt1.busy_after_req", 64'(busy1), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0); tick();
    check("mt1.valid",  64'(valid1),  64'd1);
    check("mt1.forced", 64'(forced1), 64'd1);
    check("mt1.rand",   64'(rand1),   64'd5);
    check("mt1.busy",   64'(busy1),   64'd0);
    check("r16.valid",  64'(valid2),  64'd1);
    check("r16.rand",   64'(rand2),   64'd15);
    check("r16.forced", 64'(forced2), 64'd0);
    check("def.still_busy", 64'(busy0), 64'd1);
`ifdef RNG_REJECT_COUNT_EN
    check("mt1.rej", 64'(rej1), 64'd1);
    check("r16.rej", 64'(rej2), 64'd0);
`endif
    tick();
    check("mt1.valid_one_cycle", 64'(valid1), 64'd0);

    // ---------------- randomized vs model ----------------
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0); tick();
    m0 = ref_next(m0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 10, 8);
    m1 = m0; m2 = m0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        r_r, r_e, r_l, r_q;
      logic [15:0] r_d;
      r_r = ($urandom_range(0, 299) == 0);
      r_e = $urandom_range(0, 1) == 1;
      r_l = ($urandom_range(0, 14) == 0);
      case ($urandom_range(0, 4))
        0:       r_d = 16'hFFFF;
        1:       r_d = 16'h0000;
        2:       r_d = 16'h000F;
        default: r_d = 16'($urandom);
      endcase
      r_q = ($urandom_range(0, 2) == 0);
      drive(r_r, r_e, r_l, r_d, r_q);
      m0 = ref_next(m0, r_r, r_e, r_l, r_d, r_q, 10, 8);
      m1 = ref_next(m1, r_r, r_e, r_l, r_d, r_q, 10, 1);
      m2 = ref_next(m2, r_r, r_e, r_l, r_d, r_q, 16, 8);
      tick();
      nm = $sformatf("rnd%0d", cyc);
      check({nm, ".def"}, 64'({lfsr0, busy0, valid0, rand0, forced0}),
            64'({m0.lfsr, m0.busy, m0.valid, m0.rnd, m0.forced}));
      check({nm, ".mt1"}, 64'({lfsr1, busy1, valid1, rand1, forced1}),
            64'({m1.lfsr, m1.busy, m1.valid, m1.rnd, m1.forced}));
      check({nm, ".r16"}, 64'({lfsr2, busy2, valid2, rand2, forced2}),
            64'({m2.lfsr, m2.busy, m2.valid, m2.rnd, m2.forced}));
`ifdef RNG_REJECT_COUNT_EN
      check({nm, ".rej_def"}, 64'(rej0), 64'(m0.rej));
      check({nm, ".rej_mt1"}, 64'(rej1), 64'(m1.rej));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
